// File: rtl/seg8_idx_gen.sv
// rtl/seg8_idx_gen.sv - fp16 activation to 8-segment index/offset generator
//
// Purpose:
//   Maps an fp16 activation x in [0,1) onto 8 equal segments for a
//   piecewise-linear ROM. The output is seg_o (which segment) and dx_o
//   (the offset inside that segment, in units of 1/8192). Values below
//   the range clamp low. Values at or above the range clamp high.
//   The block is a two-stage valid/ready pipeline:
//     stage 1 classifies the sample and computes the shift amount
//     stage 2 applies the shift or clamp into the output registers
//   Both stages advance together, so a stall freezes the whole pipe.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   valid_i    input sample valid
//   ready_o    block accepts input this cycle (= ready_i | ~valid_o)
//   x_i        fp16 activation input
//   valid_o    output valid
//   ready_i    downstream accepts output this cycle
//   seg_o      segment index 0..7
//   dx_o       Q0.10 offset inside the segment
//   sat_o      input clamped high (x >= 1.0, +/-inf, NaN)
//   neg_o      input clamped low (negative, nonzero)
//   Optional, present only when SEG8_IDX_STATS_EN is defined:
//   cnt_clr_i  clears both statistics counters
//   sat_cnt_o  saturating count of delivered outputs with sat_o=1
//   neg_cnt_o  saturating count of delivered outputs with neg_o=1
//
// Configuration macro: SEG8_IDX_STATS_EN (statistics counters).

module seg8_idx_gen #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] x_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [2:0]    seg_o,
  output logic [9:0]    dx_o,
  output logic          sat_o,
  output logic          neg_o
`ifdef SEG8_IDX_STATS_EN
  ,
  input  logic          cnt_clr_i,
  output logic [15:0]   sat_cnt_o,
  output logic [15:0]   neg_cnt_o
`endif
);

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_NEG  = 2'd2,
    CLS_SAT  = 2'd3
  } cls_e;

  // Stage 1 registers
  logic       s1_valid_q;
  cls_e       s1_cls_q,  s1_cls_d;
  logic [3:0] s1_sh_q,   s1_sh_d;
  logic [9:0] s1_mant_q;

  // Stage 2 / output registers
  logic       valid_q;
  logic [2:0] seg_q, seg_d;
  logic [9:0] dx_q,  dx_d;
  logic       sat_q, sat_d;
  logic       neg_q, neg_d;

  logic       adv;
  logic [4:0] exp_w;
  logic [12:0] full_w;
  logic [12:0] v_w;

  // A single advance enable keeps the stages in lockstep. Bubbles are
  // therefore never collapsed during a stall.
  assign adv     = ready_i | ~valid_q;
  assign ready_o = adv;

  // Stage 1 decode. e=31 saturates regardless of sign, so it is tested
  // first. After that, e=0 maps to zero regardless of sign.
  assign exp_w = x_i[14:10];

  always_comb begin
    s1_cls_d = CLS_NORM;
    s1_sh_d  = 4'd0;
    if (exp_w == 5'd31) begin
      s1_cls_d = CLS_SAT;
    end else if (exp_w == 5'd0) begin
      s1_cls_d = CLS_ZERO;
    end else if (x_i[15]) begin
      s1_cls_d = CLS_NEG;
    end else if (exp_w >= 5'd15) begin
      s1_cls_d = CLS_SAT;
    end else begin
      // Here e is in 1..14, so e[3:0] == e. The value v = M * 2^(e-12)
      // is realised as {M,2'b00} >> (14-e). A shift of 13 (e=1)
      // empties the 13-bit word, which is the truncate-to-zero case.
      s1_sh_d = 4'd14 - exp_w[3:0];
    end
  end

  // Stage 2 shift/clamp
  assign full_w = {1'b1, s1_mant_q, 2'b00};
  assign v_w    = full_w >> s1_sh_q;

  always_comb begin
    seg_d = 3'd0;
    dx_d  = 10'd0;
    sat_d = 1'b0;
    neg_d = 1'b0;
    case (s1_cls_q)
      CLS_NORM: begin
        seg_d = v_w[12:10];
        dx_d  = v_w[9:0];
      end
      CLS_NEG: begin
        neg_d = 1'b1;
      end
      CLS_SAT: begin
        seg_d = 3'd7;
        dx_d  = 10'h3FF;
        sat_d = 1'b1;
      end
      default: begin
        seg_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_sh_q    <= 4'd0;
      s1_mant_q  <= 10'd0;
      valid_q    <= 1'b0;
      seg_q      <= 3'd0;
      dx_q       <= 10'd0;
      sat_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= valid_i;
      valid_q    <= s1_valid_q;
      // Payload registers only load real samples. Bubbles leave the
      // previous data in place, which avoids needless toggling.
      if (valid_i) begin
        s1_cls_q  <= s1_cls_d;
        s1_sh_q   <= s1_sh_d;
        s1_mant_q <= x_i[9:0];
      end
      if (s1_valid_q) begin
        seg_q <= seg_d;
        dx_q  <= dx_d;
        sat_q <= sat_d;
        neg_q <= neg_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign seg_o   = seg_q;
  assign dx_o    = dx_q;
  assign sat_o   = sat_q;
  assign neg_o   = neg_q;

`ifdef SEG8_IDX_STATS_EN
  logic [15:0] sat_cnt_q;
  logic [15:0] neg_cnt_q;
  logic        out_hs;

  assign out_hs = valid_q & ready_i;

  // Clear wins over a same-cycle increment. The counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      sat_cnt_q <= 16'd0;
      neg_cnt_q <= 16'd0;
    end else begin
      if (out_hs && sat_q && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
      if (out_hs && neg_q && (neg_cnt_q != 16'hFFFF)) begin
        neg_cnt_q <= neg_cnt_q + 16'd1;
      end
    end
  end

  assign sat_cnt_o = sat_cnt_q;
  assign neg_cnt_o = neg_cnt_q;
`endif

endmodule
